// File: rtl/nd_2to1_rr.sv
// nd_2to1_rr: round-robin 2-to-1 merge node for 4-phase req/ack channels.
// Optional per-input accept counters under `NS_ND_2TO1_CNT_EN.
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 16
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 32
`endif

module nd_2to1_rr #(
    parameter int ASZ = `NS_ADDRESS_SIZE,
    parameter int DSZ = `NS_DATA_SIZE
) (
    input  logic           i_clk,
    input  logic           reset,
    output logic           ready,
    input  logic           rcv0_req,
    output logic           rcv0_ack,
    input  logic [ASZ-1:0] rcv0_adr,
    input  logic [DSZ-1:0] rcv0_dat,
    input  logic           rcv1_req,
    output logic           rcv1_ack,
    input  logic [ASZ-1:0] rcv1_adr,
    input  logic [DSZ-1:0] rcv1_dat,
    output logic           snd0_req,
    input  logic           snd0_ack,
    output logic [ASZ-1:0] snd0_adr,
    output logic [DSZ-1:0] snd0_dat
`ifdef NS_ND_2TO1_CNT_EN
    ,
    output logic [7:0]     cnt0,
    output logic [7:0]     cnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        RCV_REL,
        SND,
        SND_REL
    } state_t;

    state_t         state_q, state_d;
    logic           last_q, last_d;
    logic [ASZ-1:0] buf_adr_q, buf_adr_d;
    logic [DSZ-1:0] buf_dat_q, buf_dat_d;
    logic           ack0_q, ack0_d;
    logic           ack1_q, ack1_d;
    logic           req_q, req_d;
    logic           ready_q;
    logic           take0, take1;
    logic           cur_req;

    // last_q doubles as the index of the input being served
    assign cur_req = last_q ? rcv1_req : rcv0_req;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        buf_adr_d = buf_adr_q;
        buf_dat_d = buf_dat_q;
        ack0_d    = ack0_q;
        ack1_d    = ack1_q;
        req_d     = req_q;
        take0     = 1'b0;
        take1     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rcv0_req && (!rcv1_req || last_q)) begin
                    take0     = 1'b1;
                    buf_adr_d = rcv0_adr;
                    buf_dat_d = rcv0_dat;
                    ack0_d    = 1'b1;
                    last_d    = 1'b0;
                    state_d   = RCV_REL;
                end else if (rcv1_req) begin
                    take1     = 1'b1;
                    buf_adr_d = rcv1_adr;
                    buf_dat_d = rcv1_dat;
                    ack1_d    = 1'b1;
                    last_d    = 1'b1;
                    state_d   = RCV_REL;
                end
            end
            RCV_REL: begin
                if (!cur_req) begin
                    ack0_d  = 1'b0;
                    ack1_d  = 1'b0;
                    req_d   = 1'b1;
                    state_d = SND;
                end
            end
            SND: begin
                if (snd0_ack) begin
                    req_d   = 1'b0;
                    state_d = SND_REL;
                end
            end
            SND_REL: begin
                if (!snd0_ack) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (reset) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            buf_adr_q <= '0;
            buf_dat_q <= '0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            req_q     <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            buf_adr_q <= buf_adr_d;
            buf_dat_q <= buf_dat_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            req_q     <= req_d;
            ready_q   <= 1'b1;
        end
    end

    assign ready    = ready_q;
    assign rcv0_ack = ack0_q;
    assign rcv1_ack = ack1_q;
    assign snd0_req = req_q;
    assign snd0_adr = buf_adr_q;
    assign snd0_dat = buf_dat_q;

`ifdef NS_ND_2TO1_CNT_EN
    logic [7:0] cnt0_q, cnt1_q;

    // take pulses mark the edge on which the matching ack rises
    always_ff @(posedge i_clk) begin
        if (reset) begin
            cnt0_q <= 8'd0;
            cnt1_q <= 8'd0;
        end else begin
            if (take0) cnt0_q <= cnt0_q + 8'd1;
            if (take1) cnt1_q <= cnt1_q + 8'd1;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`endif

endmodule
